// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 16-bit CPU.
// Owns PC and IR, reads instructions over a req/ready port and pulses ALU/RF enables.
module cpu_sequencer #(
    parameter int              PC_W        = 8,
    parameter int              INSTR_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter logic [3:0]      HALT_OPCODE = 4'hF,
    parameter int              MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_ready,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    input  logic [3:0]         dec_alu_code,
    input  logic               dec_ram_read,
    input  logic               dec_reg_read,
    input  logic               dec_reg_write,
    input  logic               dec_pc_jump,
    input  logic [7:0]         dec_ram_adr,
    output logic               rf_re,
    output logic               alu_en,
    output logic [3:0]         alu_op,
    output logic               rf_we,
    output logic               wb_sel,
    output logic [INSTR_W-1:0] mem_data,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               halted,
    output logic               fault,
    output logic [2:0]         state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_FAULT  = 3'd7;

    localparam int              CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [2:0]         state_reg, state_next;
    logic [PC_W-1:0]    pc_reg, pc_next;
    logic [INSTR_W-1:0] ir_reg, ir_next;
    logic [INSTR_W-1:0] mem_data_reg, mem_data_next;
    logic [3:0]         alu_op_reg, alu_op_next;
    logic               wb_sel_reg, wb_sel_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [PC_W-1:0]    ram_adr_reg, ram_adr_next;
    logic               wr_pend_reg, wr_pend_next;

    logic is_halt_op;
    assign is_halt_op = (ir_reg[INSTR_W-1 -: 4] == HALT_OPCODE);

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        ir_next       = ir_reg;
        mem_data_next = mem_data_reg;
        alu_op_next   = alu_op_reg;
        wb_sel_next   = wb_sel_reg;
        cnt_next      = cnt_reg;
        ram_adr_next  = ram_adr_reg;
        wr_pend_next  = wr_pend_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                    cnt_next   = '0;
                end
            end
            S_FETCH: begin
                // Ready on the final wait cycle still completes the fetch.
                if (mem_ready) begin
                    ir_next    = mem_rdata;
                    pc_next    = pc_reg + PC_W'(1);
                    state_next = S_DECODE;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = S_FAULT;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_DECODE: begin
                if (is_halt_op) begin
                    state_next = S_HALT;
                end else if (dec_pc_jump) begin
                    pc_next    = PC_W'(dec_ram_adr);
                    state_next = S_FETCH;
                    cnt_next   = '0;
                end else begin
                    // Latch what later stages need so they do not depend on decode timing.
                    ram_adr_next = PC_W'(dec_ram_adr);
                    wr_pend_next = dec_reg_write;
                    if (dec_ram_read) begin
                        state_next = S_MEM;
                        cnt_next   = '0;
                    end else begin
                        state_next  = S_EXEC;
                        alu_op_next = dec_alu_code;
                        wb_sel_next = 1'b0;
                    end
                end
            end
            S_EXEC: begin
                state_next = wr_pend_reg ? S_WB : S_FETCH;
                cnt_next   = '0;
            end
            S_MEM: begin
                if (mem_ready) begin
                    mem_data_next = mem_rdata;
                    wb_sel_next   = 1'b1;
                    state_next    = wr_pend_reg ? S_WB : S_FETCH;
                    cnt_next      = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = S_FAULT;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_WB: begin
                state_next = S_FETCH;
                cnt_next   = '0;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            pc_reg       <= RESET_PC;
            ir_reg       <= '0;
            mem_data_reg <= '0;
            alu_op_reg   <= '0;
            wb_sel_reg   <= 1'b0;
            cnt_reg      <= '0;
            ram_adr_reg  <= '0;
            wr_pend_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            ir_reg       <= ir_next;
            mem_data_reg <= mem_data_next;
            alu_op_reg   <= alu_op_next;
            wb_sel_reg   <= wb_sel_next;
            cnt_reg      <= cnt_next;
            ram_adr_reg  <= ram_adr_next;
            wr_pend_reg  <= wr_pend_next;
        end
    end

    assign mem_req  = (state_reg == S_FETCH) || (state_reg == S_MEM);
    assign mem_addr = (state_reg == S_MEM) ? ram_adr_reg : pc_reg;
    assign instr    = ir_reg;
    assign rf_re    = (state_reg == S_DECODE) && !is_halt_op && !dec_pc_jump && dec_reg_read;
    assign alu_en   = (state_reg == S_EXEC);
    assign alu_op   = alu_op_reg;
    assign rf_we    = (state_reg == S_WB);
    assign wb_sel   = wb_sel_reg;
    assign mem_data = mem_data_reg;
    assign pc       = pc_reg;
    assign busy     = (state_reg != S_IDLE) && (state_reg != S_HALT) && (state_reg != S_FAULT);
    assign halted   = (state_reg == S_HALT);
    assign fault    = (state_reg == S_FAULT);
    assign state    = state_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-cycle vector table plus timeout and async-reset sequences.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] instr;
    logic [3:0]  dec_alu_code = '0;
    logic        dec_ram_read = 1'b0;
    logic        dec_reg_read = 1'b0;
    logic        dec_reg_write = 1'b0;
    logic        dec_pc_jump = 1'b0;
    logic [7:0]  dec_ram_adr = '0;
    logic        rf_re, alu_en, rf_we, wb_sel;
    logic [3:0]  alu_op;
    logic [15:0] mem_data;
    logic [7:0]  pc;
    logic        busy, halted, fault;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;

    cpu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .instr(instr), .dec_alu_code(dec_alu_code), .dec_ram_read(dec_ram_read),
        .dec_reg_read(dec_reg_read), .dec_reg_write(dec_reg_write), .dec_pc_jump(dec_pc_jump),
        .dec_ram_adr(dec_ram_adr), .rf_re(rf_re), .alu_en(alu_en), .alu_op(alu_op),
        .rf_we(rf_we), .wb_sel(wb_sel), .mem_data(mem_data), .pc(pc), .busy(busy),
        .halted(halted), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        rdy;
        logic [15:0] rdata;
        logic [3:0]  alu;
        logic        ram_rd;
        logic        reg_rd;
        logic        reg_wr;
        logic        jmp;
        logic [7:0]  radr;
        logic [62:0] exp;
    } vec_t;

    vec_t tv[23];

    // Expected packed outputs; status flags follow from the state code.
    function automatic logic [62:0] ex(input logic [2:0] st, input logic req, input logic [7:0] adr,
                                       input logic rfre, input logic alu, input logic [3:0] op,
                                       input logic we, input logic wbs, input logic [7:0] pcv,
                                       input logic [15:0] ir, input logic [15:0] md);
        logic b;
        b = (st >= 3'd1) && (st <= 3'd5);
        return {st, req, adr, rfre, alu, op, we, wbs, pcv, ir, md, b, st == 3'd6, st == 3'd7};
    endfunction

    function automatic vec_t mk(input logic s, input logic r, input logic [15:0] d, input logic [3:0] a,
                                input logic rr, input logic rg, input logic rw, input logic j,
                                input logic [7:0] ra, input logic [62:0] e);
        vec_t v;
        v.start = s; v.rdy = r; v.rdata = d; v.alu = a; v.ram_rd = rr; v.reg_rd = rg;
        v.reg_wr = rw; v.jmp = j; v.radr = ra; v.exp = e;
        return v;
    endfunction

    function automatic logic [62:0] got();
        return {state, mem_req, mem_addr, rf_re, alu_en, alu_op, rf_we, wb_sel, pc, instr, mem_data,
                busy, halted, fault};
    endfunction

    task automatic chk(input string name, input logic [62:0] act, input logic [62:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic [15:0] d, input logic [3:0] a,
                         input logic rr, input logic rg, input logic rw, input logic j, input logic [7:0] ra);
        start = s; mem_ready = r; mem_rdata = d; dec_alu_code = a; dec_ram_read = rr;
        dec_reg_read = rg; dec_reg_write = rw; dec_pc_jump = j; dec_ram_adr = ra;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 16'h0, 4'h0, 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // ALU + writeback
        tv[0]  = mk(1, 0, 16'h0000, 4'h0, 0, 0, 0, 0, 8'h00, ex(0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 8'h00, 16'h0000, 16'h0000));
        tv[1]  = mk(0, 1, 16'h4D00, 4'h4, 0, 1, 1, 0, 8'h00, ex(1, 1, 8'h00, 0, 0, 4'h0, 0, 0, 8'h00, 16'h0000, 16'h0000));
        tv[2]  = mk(0, 0, 16'h0000, 4'h4, 0, 1, 1, 0, 8'h00, ex(2, 0, 8'h01, 1, 0, 4'h0, 0, 0, 8'h01, 16'h4D00, 16'h0000));
        tv[3]  = mk(0, 0, 16'h0000, 4'h4, 0, 1, 1, 0, 8'h00, ex(3, 0, 8'h01, 0, 1, 4'h4, 0, 0, 8'h01, 16'h4D00, 16'h0000));
        tv[4]  = mk(0, 0, 16'h0000, 4'h4, 0, 1, 1, 0, 8'h00, ex(5, 0, 8'h01, 0, 0, 4'h4, 1, 0, 8'h01, 16'h4D00, 16'h0000));
        // Load with three wait cycles
        tv[5]  = mk(0, 1, 16'h813C, 4'h0, 1, 0, 1, 0, 8'h3C, ex(1, 1, 8'h01, 0, 0, 4'h4, 0, 0, 8'h01, 16'h4D00, 16'h0000));
        tv[6]  = mk(0, 0, 16'h0000, 4'h0, 1, 0, 1, 0, 8'h3C, ex(2, 0, 8'h02, 0, 0, 4'h4, 0, 0, 8'h02, 16'h813C, 16'h0000));
        tv[7]  = mk(0, 0, 16'hDEAD, 4'h0, 1, 0, 1, 0, 8'h3C, ex(4, 1, 8'h3C, 0, 0, 4'h4, 0, 0, 8'h02, 16'h813C, 16'h0000));
        tv[8]  = mk(0, 0, 16'hDEAD, 4'h0, 1, 0, 1, 0, 8'h3C, ex(4, 1, 8'h3C, 0, 0, 4'h4, 0, 0, 8'h02, 16'h813C, 16'h0000));
        tv[9]  = mk(0, 0, 16'hDEAD, 4'h0, 1, 0, 1, 0, 8'h3C, ex(4, 1, 8'h3C, 0, 0, 4'h4, 0, 0, 8'h02, 16'h813C, 16'h0000));
        tv[10] = mk(0, 1, 16'hBEEF, 4'h0, 1, 0, 1, 0, 8'h3C, ex(4, 1, 8'h3C, 0, 0, 4'h4, 0, 0, 8'h02, 16'h813C, 16'h0000));
        tv[11] = mk(0, 0, 16'h0000, 4'h0, 1, 0, 1, 0, 8'h3C, ex(5, 0, 8'h02, 0, 0, 4'h4, 1, 1, 8'h02, 16'h813C, 16'hBEEF));
        // Jumps, including to 8'hFF so the next fetch wraps pc
        tv[12] = mk(0, 1, 16'hC080, 4'h5, 0, 1, 0, 1, 8'h80, ex(1, 1, 8'h02, 0, 0, 4'h4, 0, 1, 8'h02, 16'h813C, 16'hBEEF));
        tv[13] = mk(0, 0, 16'h0000, 4'h5, 0, 1, 0, 1, 8'h80, ex(2, 0, 8'h03, 0, 0, 4'h4, 0, 1, 8'h03, 16'hC080, 16'hBEEF));
        tv[14] = mk(0, 1, 16'hC0FF, 4'h5, 0, 1, 0, 1, 8'hFF, ex(1, 1, 8'h80, 0, 0, 4'h4, 0, 1, 8'h80, 16'hC080, 16'hBEEF));
        tv[15] = mk(0, 0, 16'h0000, 4'h5, 0, 1, 0, 1, 8'hFF, ex(2, 0, 8'h81, 0, 0, 4'h4, 0, 1, 8'h81, 16'hC0FF, 16'hBEEF));
        tv[16] = mk(0, 1, 16'h1000, 4'h1, 0, 0, 0, 0, 8'h00, ex(1, 1, 8'hFF, 0, 0, 4'h4, 0, 1, 8'hFF, 16'hC0FF, 16'hBEEF));
        // ALU op without writeback returns straight to FETCH
        tv[17] = mk(0, 0, 16'h0000, 4'h1, 0, 0, 0, 0, 8'h00, ex(2, 0, 8'h00, 0, 0, 4'h4, 0, 1, 8'h00, 16'h1000, 16'hBEEF));
        tv[18] = mk(0, 0, 16'h0000, 4'h1, 0, 0, 0, 0, 8'h00, ex(3, 0, 8'h00, 0, 1, 4'h1, 0, 0, 8'h00, 16'h1000, 16'hBEEF));
        // Halt outranks a simultaneous jump; start ignored afterwards
        tv[19] = mk(0, 1, 16'hF000, 4'h0, 0, 0, 0, 1, 8'h55, ex(1, 1, 8'h00, 0, 0, 4'h1, 0, 0, 8'h00, 16'h1000, 16'hBEEF));
        tv[20] = mk(0, 0, 16'h0000, 4'h0, 0, 1, 1, 1, 8'h55, ex(2, 0, 8'h01, 0, 0, 4'h1, 0, 0, 8'h01, 16'hF000, 16'hBEEF));
        tv[21] = mk(1, 1, 16'h1234, 4'h0, 0, 0, 0, 0, 8'h00, ex(6, 0, 8'h01, 0, 0, 4'h1, 0, 0, 8'h01, 16'hF000, 16'hBEEF));
        tv[22] = mk(0, 1, 16'h1234, 4'h0, 0, 0, 0, 0, 8'h00, ex(6, 0, 8'h01, 0, 0, 4'h1, 0, 0, 8'h01, 16'hF000, 16'hBEEF));

        @(negedge clk);
        #1;
        chk("reset_state", got(), ex(0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 8'h00, 16'h0000, 16'h0000));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(tv[i].start, tv[i].rdy, tv[i].rdata, tv[i].alu, tv[i].ram_rd, tv[i].reg_rd,
                  tv[i].reg_wr, tv[i].jmp, tv[i].radr);
            #1;
            chk($sformatf("vec%0d", i), got(), tv[i].exp);
            $display("vec%0d state=%0d pc=%h ir=%h", i, state, pc, instr);
        end

        // Fetch never answered: 16 wait cycles then FAULT with pc unchanged
        do_reset();
        @(negedge clk);
        drive(1, 0, 16'h0, 4'h0, 0, 0, 0, 0, 8'h00);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            drive(0, 0, 16'h0, 4'h0, 0, 0, 0, 0, 8'h00);
            #1;
            chk($sformatf("tmo_wait%0d", k), {60'd0, state}, {60'd0, 3'd1});
        end
        @(negedge clk);
        #1;
        chk("tmo_fault", got(), ex(7, 0, 8'h00, 0, 0, 4'h0, 0, 0, 8'h00, 16'h0000, 16'h0000));
        $display("timeout: state=%0d fault=%0d pc=%h", state, fault, pc);

        // Ready on the 16th fetch cycle completes normally
        do_reset();
        @(negedge clk);
        drive(1, 0, 16'h0, 4'h0, 0, 0, 0, 0, 8'h00);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            drive(0, (k == 16), 16'h2000, 4'h0, 0, 0, 0, 0, 8'h00);
            #1;
            chk($sformatf("late_wait%0d", k), {60'd0, state}, {60'd0, 3'd1});
        end
        @(negedge clk);
        #1;
        chk("late_ready", got(), ex(2, 0, 8'h01, 0, 0, 4'h0, 0, 0, 8'h01, 16'h2000, 16'h0000));
        $display("late ready: state=%0d fault=%0d pc=%h", state, fault, pc);

        // Asynchronous reset while waiting in MEM
        do_reset();
        @(negedge clk);
        drive(1, 0, 16'h0, 4'h0, 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        drive(0, 1, 16'h8000, 4'h0, 1, 0, 1, 0, 8'h3C);
        @(negedge clk);
        drive(0, 0, 16'h0, 4'h0, 1, 0, 1, 0, 8'h3C);
        @(negedge clk);
        #1;
        chk("pre_rst_mem", got(), ex(4, 1, 8'h3C, 0, 0, 4'h0, 0, 0, 8'h01, 16'h8000, 16'h0000));
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst", got(), ex(0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 8'h00, 16'h0000, 16'h0000));
        $display("async reset: state=%0d pc=%h mem_req=%0d", state, pc, mem_req);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 16'h1111, 4'h0, 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        #1;
        chk("post_rst_idle", got(), ex(0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 8'h00, 16'h0000, 16'h0000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
